// File: rtl/pipe_reg_chain.sv
// Elastic pipeline-register chain: each stage holds valid, instruction and payload,
// with global stall, per-stage flush and taps. PIPE_REG_CHAIN_PERF_EN adds perf counters.
module pipe_reg_chain #(
  parameter int          DEPTH    = 2,
  parameter int          WIDTH    = 96,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic [DEPTH-1:0]    flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_inst,
  input  logic [WIDTH-1:0]    in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_inst,
  output logic [WIDTH-1:0]    out_data,
  output logic [DEPTH-1:0]    tap_valid,
  output logic [32*DEPTH-1:0] tap_inst,
  output logic [3:0]          occupancy
`ifdef PIPE_REG_CHAIN_PERF_EN
  ,
  output logic [31:0]         perf_bubbles,
  output logic [31:0]         perf_flushes
`endif
);

  logic [DEPTH-1:0] v_cur;
  logic [DEPTH-1:0] v_next;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] src_valid;
  logic [31:0]      inst_cur [DEPTH];
  logic [31:0]      src_inst [DEPTH];
  logic [WIDTH-1:0] data_cur [DEPTH];
  logic [WIDTH-1:0] src_data [DEPTH];

  // A stage may advance if anything downstream of it (or the consumer) has room.
  always_comb begin : adv_chain
    logic room;
    room = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      room   = room | ~v_cur[i];
      adv[i] = room & ~stall;
    end
  end

  assign in_ready = adv[0];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic             v_reg;
      logic             v_nx;
      logic [31:0]      inst_reg;
      logic [31:0]      inst_nx;
      logic [WIDTH-1:0] data_reg;
      logic [WIDTH-1:0] data_nx;

      if (gi == 0) begin : g_src_in
        assign src_valid[gi] = in_valid;
        assign src_inst[gi]  = in_inst;
        assign src_data[gi]  = in_data;
      end else begin : g_src_prev
        // An entry being flushed out of the previous stage is killed, not forwarded.
        assign src_valid[gi] = v_cur[gi-1] & ~flush[gi-1];
        assign src_inst[gi]  = inst_cur[gi-1];
        assign src_data[gi]  = data_cur[gi-1];
      end

      always_comb begin
        v_nx    = v_reg;
        inst_nx = inst_reg;
        data_nx = data_reg;
        if (flush[gi] || (adv[gi] && !src_valid[gi])) begin
          v_nx    = 1'b0;
          inst_nx = NOP_INST;
          data_nx = '0;
        end else if (adv[gi]) begin
          v_nx    = 1'b1;
          inst_nx = src_inst[gi];
          data_nx = src_data[gi];
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          v_reg    <= 1'b0;
          inst_reg <= NOP_INST;
          data_reg <= '0;
        end else begin
          v_reg    <= v_nx;
          inst_reg <= inst_nx;
          data_reg <= data_nx;
        end
      end

      assign v_cur[gi]              = v_reg;
      assign v_next[gi]             = v_nx;
      assign inst_cur[gi]           = inst_reg;
      assign data_cur[gi]           = data_reg;
      assign tap_inst[32*gi +: 32]  = inst_reg;
    end
  endgenerate

  assign tap_valid = v_cur;
  assign out_valid = v_cur[DEPTH-1];
  assign out_inst  = inst_cur[DEPTH-1];
  assign out_data  = data_cur[DEPTH-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) occupancy <= 4'd0;
    else        occupancy <= 4'($countones(v_next));
  end

`ifdef PIPE_REG_CHAIN_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_bubbles <= 32'd0;
      perf_flushes <= 32'd0;
    end else begin
      if (!stall && !out_valid) perf_bubbles <= perf_bubbles + 32'd1;
      perf_flushes <= perf_flushes + 32'($countones(flush & v_cur));
    end
  end
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Self-checking bench for pipe_reg_chain (DEPTH=3): directed steps plus random traffic
// compared against a slot-compaction reference model.
module tb_pipe_reg_chain;
  localparam int          DEPTH = 3;
  localparam int          WIDTH = 16;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                stall = 1'b0;
  logic [DEPTH-1:0]    flush = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [31:0]         in_inst = '0;
  logic [WIDTH-1:0]    in_data = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [31:0]         out_inst;
  logic [WIDTH-1:0]    out_data;
  logic [DEPTH-1:0]    tap_valid;
  logic [32*DEPTH-1:0] tap_inst;
  logic [3:0]          occupancy;
`ifdef PIPE_REG_CHAIN_PERF_EN
  logic [31:0]         perf_bubbles;
  logic [31:0]         perf_flushes;
  logic [31:0]         exp_bub;
  logic [31:0]         exp_fl;
`endif

  pipe_reg_chain #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NOP_INST(NOP)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_data(out_data),
    .tap_valid(tap_valid), .tap_inst(tap_inst), .occupancy(occupancy)
`ifdef PIPE_REG_CHAIN_PERF_EN
    , .perf_bubbles(perf_bubbles), .perf_flushes(perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: slot contents, slot DEPTH-1 is the output slot.
  logic             mv [DEPTH];
  logic [31:0]      mi [DEPTH];
  logic [WIDTH-1:0] md [DEPTH];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(mv[i]);
    return c;
  endfunction

  function automatic logic model_in_ready();
    return !stall && (out_ready || model_count() < DEPTH);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      mv[i] = 1'b0; mi[i] = NOP; md[i] = '0;
    end
`ifdef PIPE_REG_CHAIN_PERF_EN
    exp_bub = 0; exp_fl = 0;
`endif
  endtask

  // Entries slide forward into any hole (the output slot empties when consumed),
  // the input fills slot 0 if it is free; then flushed slots and entries that
  // left a flushed slot are killed.
  task automatic model_step();
    logic             cv [DEPTH];
    logic [31:0]      ci [DEPTH];
    logic [WIDTH-1:0] cd [DEPTH];
    int               org [DEPTH];
    logic             rdy;
    rdy = model_in_ready();
`ifdef PIPE_REG_CHAIN_PERF_EN
    if (!stall && !mv[DEPTH-1]) exp_bub++;
    for (int i = 0; i < DEPTH; i++) if (flush[i] && mv[i]) exp_fl++;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      cv[i] = mv[i]; ci[i] = mi[i]; cd[i] = md[i]; org[i] = i;
    end
    if (!stall) begin
      if (out_ready && cv[DEPTH-1]) cv[DEPTH-1] = 1'b0;
      for (int i = DEPTH - 1; i >= 1; i--) begin
        if (!cv[i]) begin
          cv[i] = cv[i-1]; ci[i] = ci[i-1]; cd[i] = cd[i-1]; org[i] = org[i-1];
          cv[i-1] = 1'b0;
        end
      end
      if (rdy && in_valid) begin
        cv[0] = 1'b1; ci[0] = in_inst; cd[0] = in_data; org[0] = -1;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (flush[i] || (org[i] >= 0 && flush[org[i]])) cv[i] = 1'b0;
      if (!cv[i]) begin ci[i] = NOP; cd[i] = '0; end
      mv[i] = cv[i]; mi[i] = ci[i]; md[i] = cd[i];
    end
  endtask

  task automatic check_state();
    logic [DEPTH-1:0] tv;
    for (int i = 0; i < DEPTH; i++) begin
      tv[i] = mv[i];
      check("tap_inst", 128'(tap_inst[32*i +: 32]), 128'(mi[i]));
    end
    check("tap_valid", 128'(tap_valid), 128'(tv));
    check("out_valid", 128'(out_valid), 128'(mv[DEPTH-1]));
    check("out_inst", 128'(out_inst), 128'(mi[DEPTH-1]));
    check("out_data", 128'(out_data), 128'(md[DEPTH-1]));
    check("occupancy", 128'(occupancy), 128'(model_count()));
`ifdef PIPE_REG_CHAIN_PERF_EN
    check("perf_bubbles", 128'(perf_bubbles), 128'(exp_bub));
    check("perf_flushes", 128'(perf_flushes), 128'(exp_fl));
`endif
  endtask

  // Called just after a rising edge: drive, check in_ready, advance model, check state.
  task automatic cycle(input logic st, input logic [DEPTH-1:0] fl, input logic iv,
                       input logic [31:0] ii, input logic [WIDTH-1:0] id, input logic ordy);
    stall = st; flush = fl; in_valid = iv; in_inst = ii; in_data = id; out_ready = ordy;
    #1;
    check("in_ready", 128'(in_ready), 128'(model_in_ready()));
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check_state();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_state();
    reset = 1'b1;

    // Single instruction transit
    cycle(0, 3'b000, 1, 32'h00A00093, 16'h1111, 1);
    cycle(0, 3'b000, 0, 32'h0, 16'h0, 1);
    cycle(0, 3'b000, 0, 32'h0, 16'h0, 1);
    check("t1_out_valid", 128'(out_valid), 128'(1));
    check("t1_out_inst", 128'(out_inst), 128'(32'h00A00093));
    cycle(0, 3'b000, 0, 32'h0, 16'h0, 1);

    // Fill, hold under back-pressure, then drain in order
    for (int k = 0; k < 3; k++) cycle(0, 3'b000, 1, 32'h100 + k, 16'(k + 1), 0);
    for (int k = 0; k < 5; k++) cycle(0, 3'b000, 1, 32'hDEAD, 16'hBEEF, 0);
    check("t2_in_ready_full", 128'(in_ready), 128'(0));
    check("t2_out_inst_held", 128'(out_inst), 128'(32'h100));
    for (int k = 0; k < 4; k++) cycle(0, 3'b000, 0, 32'h0, 16'h0, 1);

    // Streaming with a two-cycle stall
    for (int k = 0; k < 8; k++) cycle((k == 3) || (k == 4), 3'b000, 1, 32'h200 + k, 16'(k), 1);
    for (int k = 0; k < 4; k++) cycle(0, 3'b000, 0, 32'h0, 16'h0, 1);

    // Flush stages 0 and 1
    cycle(0, 3'b000, 1, 32'h301, 16'h31, 1);
    cycle(0, 3'b000, 1, 32'h302, 16'h32, 1);
    cycle(0, 3'b011, 0, 32'h0, 16'h0, 1);
    check("t4_tap_valid", 128'(tap_valid), 128'(0));
    check("t4_tap_inst_lo", 128'(tap_inst[63:0]), 128'({NOP, NOP}));

    // Flush last stage during stall
    for (int k = 0; k < 3; k++) cycle(0, 3'b000, 1, 32'h400 + k, 16'(k), 0);
    cycle(1, 3'b100, 1, 32'h4FF, 16'h0, 0);
    for (int k = 0; k < 4; k++) cycle(0, 3'b000, 0, 32'h0, 16'h0, 1);

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      cycle(($urandom % 8) == 0,
            (($urandom % 6) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
            1'($urandom), $urandom, 16'($urandom), ($urandom % 4) != 0);
    end

    // Asynchronous reset mid-stream with two entries in flight
    for (int k = 0; k < 4; k++) cycle(0, 3'b000, 0, 32'h0, 16'h0, 1);
    cycle(0, 3'b000, 1, 32'h501, 16'h51, 0);
    cycle(0, 3'b000, 1, 32'h502, 16'h52, 0);
    check("t6_occ_before", 128'(occupancy), 128'(2));
    stall = 1'b0; in_valid = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    model_reset();
    check_state();
    check("t6_out_inst", 128'(out_inst), 128'(32'h13));
    check("t6_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
    reset = 1'b1;
    cycle(0, 3'b000, 1, 32'h601, 16'h61, 1);
    for (int k = 0; k < 3; k++) cycle(0, 3'b000, 0, 32'h0, 16'h0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
- Parametrised pipeline-register chain replacing the bare per-signal flip-flops between core stages.
- Each stage carries a valid bit, a WIDTH-bit payload and a 32-bit instruction word.
- Adds elastic back-pressure, a global stall, per-stage flush with NOP/bubble injection, and per-stage taps for forwarding/hazard logic.
- Sits between Stage1/Stage2/Stage3 of the core, or any multi-cycle datapath.

Parameters:
- DEPTH, 2, number of register stages (1..8).
- WIDTH, 96, payload bits per stage (pc/imm/operands concatenated by the instantiator).
- NOP_INST, 32'h0000_0013, instruction word loaded into a stage when it becomes a bubble (addi x0,x0,0).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- stall  input  1  global freeze from the memory system; 1 holds every stage.
- flush  input  DEPTH  per-stage kill; bit i clears stage i at the next edge.
- in_valid  input  1  upstream has an entry.
- in_ready  output  1  chain accepts an entry this cycle.
- in_inst  input  32  upstream instruction word.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  last stage holds a valid entry.
- out_ready  input  1  downstream consumes the last stage.
- out_inst  output  32  last-stage instruction (NOP_INST when bubble).
- out_data  output  WIDTH  last-stage payload.
- tap_valid  output  DEPTH  valid bit of every stage; bit 0 is the entry stage.
- tap_inst  output  32*DEPTH  instruction of every stage, stage i at bits [32i+31:32i].
- occupancy  output  4  number of valid stages (0..DEPTH), registered.

Behaviour:
- Reset (reset==0, async):
  - all v[i]=0, inst[i]=NOP_INST, data[i]=0, occupancy=0.
  - Hence out_valid=0, out_inst=NOP_INST, out_data=0.
  - in_ready is combinational and evaluates to 1 while stall==0.
- Advance enables (combinational):
  - adv[DEPTH-1] = out_ready | ~v[DEPTH-1].
  - adv[i] = adv[i+1] | ~v[i].
  - When stall==1, every adv is forced to 0.
- in_ready = adv[0] & ~stall. Zero latency from in_ready to accept.
- At the clock edge, for each stage i, in priority order:
  - flush[i]==1 → v=0, inst=NOP_INST, data=0. Flush wins over stall and over load.
  - else if stall==1 → hold.
  - else if adv[i] → load from stage i-1 (stage 0 loads from in_*). If the source is invalid, the stage becomes a bubble (v=0, inst=NOP_INST, data=0).
  - else → hold.
- Entry accept: in_valid & in_ready & ~flush[0].
- Exit fire: out_valid & out_ready & ~stall.
- Latency: an accepted entry reaches out_* exactly DEPTH edges later if never blocked or flushed.
- Full chain with out_ready==0:
  - all adv=0, in_ready=0, contents held. No overwrite, no loss.
- Partially-full chain with out_ready==0:
  - bubbles collapse; upstream stages advance into empty stages.
- Simultaneous cases:
  - Exit and entry on the same edge → occupancy unchanged.
  - Flush on a stage that is receiving data → stage ends as bubble and the entry is dropped. Upstream still sees in_ready as computed, no retry.
- occupancy is the registered popcount of the next-state v vector. Width is fixed at 4 bits; DEPTH ≤ 8 keeps it from wrapping.
- DEPTH==1: adv[0] = out_ready | ~v[0]; single-entry skid register.
- Mid-operation reset clears all state immediately. in_ready recovers as soon as reset deasserts.

Optional Feature:
- Macro PIPE_REG_CHAIN_PERF_EN.
- Defined: adds outputs perf_bubbles (32) and perf_flushes (32), both reset to 0 and wrapping at 2^32.
  - perf_bubbles increments each cycle stall==0 && out_valid==0.
  - perf_flushes adds popcount(flush & tap_valid) each cycle, i.e. valid entries killed.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- DEPTH=3; reset low for 2 cycles, then high; push inst 0x00A00093 with in_valid=1, out_ready=1 → out_valid=1 with out_inst=0x00A00093 on the 3rd edge; occupancy 1 throughout transit.
- Fill 3 entries, then out_ready=0 → in_ready=0, occupancy=3, out_inst stable for 5 cycles. Then out_ready=1 → one entry exits per cycle in FIFO order.
- Streaming with stall=1 for 2 cycles → all tap_inst unchanged, in_ready=0, no entry lost or duplicated.
- Stages 0 and 1 valid, flush=3'b011 → next edge tap_valid=3'b000 and tap_inst[63:0]={NOP_INST,NOP_INST}. With PERF_EN, perf_flushes=2.
- flush[2] asserted together with stall=1 → stage 2 cleared despite the stall; other stages held.
- Assert reset=0 mid-stream with occupancy=2 → tap_valid=0, occupancy=0 and out_inst=0x00000013 immediately, without waiting for a clock edge.
